// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI mode-0 target.
package spi_target_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int BIT_CNT_W = 3;
  localparam logic [7:0] FILL_BYTE_DEFAULT = 8'hFF;

endpackage

// File: rtl/spi_target_sync.sv
// Two-flop synchronizers for sck/csn/mosi plus edge strobes on sck and csn.
module spi_target_sync
  import spi_target_pkg::*;
(
  input  logic clk_i,
  input  logic rstn_i,
  input  logic sck_i,
  input  logic csn_i,
  input  logic mosi_i,
  output logic mosi_s,
  output logic sck_rise,
  output logic sck_fall,
  output logic csn_fall,
  output logic csn_rise
);

  logic [1:0] sck_ff;
  logic [1:0] csn_ff;
  logic [1:0] mosi_ff;
  logic [1:0] vld;
  logic       sck_d;
  logic       csn_d;

  // csn history only tracks pin-derived samples (vld), so a csn held low
  // across reset never looks like a fresh fall.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sck_ff  <= 2'b00;
      csn_ff  <= 2'b11;
      mosi_ff <= 2'b00;
      vld     <= 2'b00;
      sck_d   <= 1'b0;
      csn_d   <= 1'b0;
    end else begin
      sck_ff  <= {sck_ff[0], sck_i};
      csn_ff  <= {csn_ff[0], csn_i};
      mosi_ff <= {mosi_ff[0], mosi_i};
      vld     <= {vld[0], 1'b1};
      sck_d   <= sck_ff[1];
      csn_d   <= vld[1] ? csn_ff[1] : 1'b0;
    end
  end

  assign mosi_s   = mosi_ff[1];
  assign sck_rise = sck_ff[1] & ~sck_d;
  assign sck_fall = ~sck_ff[1] & sck_d;
  assign csn_fall = csn_d & ~csn_ff[1];
  assign csn_rise = vld[1] & csn_ff[1] & ~csn_d;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target with byte streams for RX and TX.
// Optional sticky overrun/underrun flags when SPI_TARGET_ERR_EN is defined.
//
// state | meaning
// IDLE  | csn high, waiting for a csn fall; miso driven 0, pad disabled
// SHIFT | selected; sample mosi on sck rise, shift miso on sck fall
module spi_target
  import spi_target_pkg::*;
#(
  parameter logic [7:0] FILL_BYTE = FILL_BYTE_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       sck_i,
  input  logic       csn_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_oe_o,
  output logic [7:0] out_data_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  input  logic [7:0] in_data_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
`ifdef SPI_TARGET_ERR_EN
  output logic       overrun_o,
  output logic       underrun_o,
  input  logic       clear_err_i,
`endif
  output logic       busy_o
);

  state_t               state;
  state_t               state_nxt;
  logic                 mosi_s;
  logic                 sck_rise;
  logic                 sck_fall;
  logic                 csn_fall;
  logic                 csn_rise;
  logic                 tx_load;
  logic                 tx_shift;
  logic                 rx_shift;
  logic                 byte_done;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [7:0]           rx_sr;
  logic [7:0]           tx_sr;

  spi_target_sync u_sync (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .sck_i    (sck_i),
    .csn_i    (csn_i),
    .mosi_i   (mosi_i),
    .mosi_s   (mosi_s),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .csn_fall (csn_fall),
    .csn_rise (csn_rise)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_load   = 1'b0;
    tx_shift  = 1'b0;
    rx_shift  = 1'b0;
    case (state)
      IDLE: begin
        if (csn_fall) begin
          state_nxt = SHIFT;
          tx_load   = 1'b1;
        end
      end
      SHIFT: begin
        if (csn_rise) begin
          state_nxt = IDLE;
        end else begin
          rx_shift = sck_rise;
          if (sck_fall) begin
            if (bit_cnt == '0) tx_load  = 1'b1;
            else               tx_shift = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o     = (state == SHIFT);
  assign miso_oe_o  = busy_o;
  assign miso_o     = busy_o & tx_sr[7];
  assign in_ready_o = tx_load;

  // A csn rise throws away any partial RX byte and unsent TX bits.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      bit_cnt   <= '0;
      rx_sr     <= 8'h00;
      tx_sr     <= 8'h00;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (csn_rise) begin
        bit_cnt <= '0;
        rx_sr   <= 8'h00;
        tx_sr   <= 8'h00;
      end else begin
        if (rx_shift) begin
          rx_sr     <= {rx_sr[6:0], mosi_s};
          bit_cnt   <= bit_cnt + 1'b1;
          byte_done <= (bit_cnt == '1);
        end
        if (tx_load)       tx_sr <= in_valid_i ? in_data_i : FILL_BYTE;
        else if (tx_shift) tx_sr <= {tx_sr[6:0], 1'b0};
      end
    end
  end

  // A new byte may replace the held one only when it is accepted this cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_data_o  <= 8'h00;
      out_valid_o <= 1'b0;
    end else if (byte_done) begin
      if (!out_valid_o || out_ready_i) begin
        out_data_o  <= rx_sr;
        out_valid_o <= 1'b1;
      end
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

`ifdef SPI_TARGET_ERR_EN
  logic overrun_set;
  assign overrun_set = byte_done & out_valid_o & ~out_ready_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      overrun_o  <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      if (clear_err_i) begin
        overrun_o  <= 1'b0;
        underrun_o <= 1'b0;
      end
      if (overrun_set)            overrun_o  <= 1'b1;
      if (tx_load && !in_valid_i) underrun_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_target.sv
// Randomized bench for spi_target against a byte-stream reference model.
module tb_spi_target;

  localparam int         H    = 50;
  localparam logic [7:0] FILL = 8'hFF;

  logic       clk_i = 1'b0;
  logic       rstn_i, sck_i, csn_i, mosi_i;
  logic       miso_o, miso_oe_o, out_valid_o, out_ready_i;
  logic       in_valid_i, in_ready_o, busy_o;
  logic [7:0] out_data_o, in_data_i;
`ifdef SPI_TARGET_ERR_EN
  logic       overrun_o, underrun_o, clear_err_i;
`endif

  int   checks   = 0;
  int   failures = 0;
  int   rdy_cnt  = 0;
  bit   pop_pend = 1'b0;
  bit   tx_en    = 1'b0;
  logic [7:0] tx_q[$];
  logic [7:0] got_rx[$];
  logic [7:0] exp_rx[$];
  logic [7:0] mosi_bytes[$];

  always #5 clk_i = ~clk_i;

  spi_target dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .sck_i       (sck_i),
    .csn_i       (csn_i),
    .mosi_i      (mosi_i),
    .miso_o      (miso_o),
    .miso_oe_o   (miso_oe_o),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .in_data_i   (in_data_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
`ifdef SPI_TARGET_ERR_EN
    .overrun_o   (overrun_o),
    .underrun_o  (underrun_o),
    .clear_err_i (clear_err_i),
`endif
    .busy_o      (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic refresh_in();
    in_valid_i = tx_en && (tx_q.size() != 0);
    in_data_i  = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
  endtask

  // Stream monitors: IN-byte consumption and accepted OUT beats.
  always @(negedge clk_i) begin
    if (in_ready_o) begin
      rdy_cnt++;
      if (in_valid_i) pop_pend = 1'b1;
    end
    if (out_valid_o && out_ready_i) got_rx.push_back(out_data_o);
  end

  always @(posedge clk_i) begin
    if (pop_pend) begin
      #1;
      void'(tx_q.pop_front());
      pop_pend = 1'b0;
      refresh_in();
    end
  end

  task automatic sbit(input logic b, output logic m);
    sck_i  = 1'b0;
    mosi_i = b;
    #(H);
    m     = miso_o;
    sck_i = 1'b1;
    #(H);
  endtask

  // One csn-framed transfer of nbits from mosi_bytes; the initiator releases
  // csn while sck is still high, so no TX load follows the last bit.
  task automatic xfer(input int nbits);
    int         nb, avail, base, r;
    logic [7:0] expm[$];
    logic [7:0] cap, cur, mask;
    logic       m;
    nb    = (nbits + 7) / 8;
    avail = tx_en ? tx_q.size() : 0;
    base  = rdy_cnt;
    for (int k = 0; k < nb; k++) expm.push_back(k < avail ? tx_q[k] : FILL);
    cap   = 8'h00;
    csn_i = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      cur = mosi_bytes[i / 8];
      sbit(cur[7 - (i % 8)], m);
      if (i == 0) chk("busy_oe", {busy_o, miso_oe_o}, 2'b11);
      cap = {cap[6:0], m};
      if (i % 8 == 7) begin
        chk("miso_byte", cap, expm[i / 8]);
        exp_rx.push_back(cur);
      end
    end
    r = nbits % 8;
    if (r != 0) begin
      mask = 8'((1 << r) - 1);
      cur  = expm[nb - 1];
      chk("miso_partial", cap & mask, cur >> (8 - r));
    end
    csn_i = 1'b1;
    #(H);
    sck_i = 1'b0;
    #(3 * H);
    chk("in_ready_pulses", rdy_cnt - base, nb);
    chk("idle_pins", {busy_o, miso_oe_o, miso_o}, 3'b000);
  endtask

  task automatic check_rx();
    chk("rx_count", got_rx.size(), exp_rx.size());
    for (int i = 0; i < got_rx.size() && i < exp_rx.size(); i++)
      chk("rx_data", got_rx[i], exp_rx[i]);
    got_rx.delete();
    exp_rx.delete();
  endtask

`ifdef SPI_TARGET_ERR_EN
  task automatic clear_flags();
    @(posedge clk_i); #1; clear_err_i = 1'b1;
    @(posedge clk_i); #1; clear_err_i = 1'b0;
    @(negedge clk_i);
    chk("flags_cleared", {overrun_o, underrun_o}, 2'b00);
  endtask
`endif

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n, snap;
    logic       m;
    logic [7:0] b;
    rstn_i = 1'b0; sck_i = 1'b0; csn_i = 1'b1; mosi_i = 1'b0;
    out_ready_i = 1'b0;
`ifdef SPI_TARGET_ERR_EN
    clear_err_i = 1'b0;
`endif
    refresh_in();
    repeat (3) @(negedge clk_i);
    chk("reset_outputs", {out_valid_o, out_data_o, miso_o, miso_oe_o, in_ready_o, busy_o}, 0);
    rstn_i = 1'b1;
    repeat (5) @(negedge clk_i);

    // single byte
    out_ready_i = 1'b1; tx_en = 1'b1;
    tx_q = '{8'h3C}; refresh_in();
    mosi_bytes = '{8'hA5};
    xfer(8);
    check_rx();

    // burst
    tx_q = '{8'h10, 8'h11, 8'h12, 8'h13}; refresh_in();
    mosi_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
    xfer(32);
    check_rx();

    // overrun: the second byte is dropped, the first is held
    out_ready_i = 1'b0;
    mosi_bytes = '{8'h11, 8'h22};
    xfer(16);
    exp_rx.delete(); exp_rx.push_back(8'h11);
    chk("overrun_hold", {out_valid_o, out_data_o}, {1'b1, 8'h11});
`ifdef SPI_TARGET_ERR_EN
    chk("overrun_flag", overrun_o, 1'b1);
`endif
    @(posedge clk_i); #1; out_ready_i = 1'b1;
    @(posedge clk_i); #1; out_ready_i = 1'b0;
    @(negedge clk_i);
    chk("overrun_drained", out_valid_o, 1'b0);
    check_rx();
    out_ready_i = 1'b1;

    // underrun
`ifdef SPI_TARGET_ERR_EN
    clear_flags();
`endif
    tx_en = 1'b0; tx_q = '{8'h99}; refresh_in();
    mosi_bytes = '{8'($urandom)};
    xfer(8);
    check_rx();
`ifdef SPI_TARGET_ERR_EN
    chk("underrun_flag", {overrun_o, underrun_o}, 2'b01);
    clear_flags();
`endif
    tx_q.delete(); tx_en = 1'b1; refresh_in();

    // abort after 5 bits, then a full byte
    tx_q = '{8'hAB, 8'hCD}; refresh_in();
    mosi_bytes = '{8'($urandom)};
    xfer(5);
    mosi_bytes = '{8'h5A};
    xfer(8);
    check_rx();
    chk("abort_tx_left", tx_q.size(), 0);

    // randomized transfers
    repeat (6) begin
      n = $urandom_range(1, 3);
      mosi_bytes.delete(); tx_q.delete();
      for (int k = 0; k < n; k++) mosi_bytes.push_back(8'($urandom));
      for (int k = 0; k < int'($urandom_range(0, n)); k++) tx_q.push_back(8'($urandom));
      refresh_in();
      xfer(8 * n);
      check_rx();
    end
    tx_q.delete(); refresh_in();

    // reset mid-byte with a byte already held on the output
    out_ready_i = 1'b0;
    mosi_bytes = '{8'h77};
    xfer(8);
    exp_rx.delete();
    chk("held_before_reset", {out_valid_o, out_data_o}, {1'b1, 8'h77});
    csn_i = 1'b0;
    b = 8'hC3;
    for (int i = 0; i < 4; i++) sbit(b[7 - i], m);
    chk("busy_mid_byte", busy_o, 1'b1);
    @(negedge clk_i); rstn_i = 1'b0;
    @(negedge clk_i);
    chk("reset_mid_outputs", {out_valid_o, out_data_o, miso_o, miso_oe_o, in_ready_o, busy_o}, 0);
`ifdef SPI_TARGET_ERR_EN
    chk("reset_mid_flags", {overrun_o, underrun_o}, 2'b00);
`endif
    @(negedge clk_i); rstn_i = 1'b1;
    out_ready_i = 1'b1;
    snap = rdy_cnt;
    b = 8'($urandom);
    for (int i = 0; i < 8; i++) sbit(b[7 - i], m);
    chk("orphan_pulses", rdy_cnt - snap, 0);
    chk("orphan_busy", busy_o, 1'b0);
    csn_i = 1'b1;
    #(H);
    sck_i = 1'b0;
    #(3 * H);
    check_rx();
    tx_q = '{8'($urandom)}; refresh_in();
    mosi_bytes = '{8'($urandom)};
    xfer(8);
    check_rx();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
